viterbi_frame_ctrl: RTL and testbench

VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

---
 rtl/viterbi_pkg.sv | 18 +
 rtl/viterbi_frame_ctrl_if.sv | 35 +++
 rtl/vit_frame_cnt.sv | 27 ++
 rtl/viterbi_frame_ctrl.sv | 117 +++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and FSM encoding for the Viterbi frame controller,
// also referenced by the ACSU/TBU datapath blocks.
package viterbi_pkg;

  localparam int unsigned TBL      = 15;
  localparam int unsigned TAIL_LEN = 2;
  localparam int unsigned LEN_W    = 12;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOAD,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Frame-controller signal bundle: control, symbol stream in, datapath strobe
// out, decoded bits in/out. master = controller side, slave = environment.
interface viterbi_frame_ctrl_if #(
  parameter int unsigned LEN_W = viterbi_pkg::LEN_W
);
  logic             start_i;
  logic [LEN_W-1:0] frame_len_i;
  logic             abort_i;
  logic             sym_valid_i;
  logic [1:0]       sym_i;
  logic             sym_ready_o;
  logic             dp_init_o;
  logic             dp_valid_o;
  logic [1:0]       dp_sym_o;
  logic             dec_valid_i;
  logic             dec_bit_i;
  logic             out_valid_o;
  logic             out_bit_o;
  logic             out_last_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  modport master (
    input  start_i, frame_len_i, abort_i, sym_valid_i, sym_i, dec_valid_i, dec_bit_i,
    output sym_ready_o, dp_init_o, dp_valid_o, dp_sym_o,
           out_valid_o, out_bit_o, out_last_o, busy_o, done_o, err_o
  );

  modport slave (
    output start_i, frame_len_i, abort_i, sym_valid_i, sym_i, dec_valid_i, dec_bit_i,
    input  sym_ready_o, dp_init_o, dp_valid_o, dp_sym_o,
           out_valid_o, out_bit_o, out_last_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/vit_frame_cnt.sv
// Loadable up-counter with terminal-count flag (count == term).
module vit_frame_cnt #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Viterbi frame controller: feeds a frame plus TBL flush symbols into the
// decoder chain, forwards data bits (tail dropped) and reports completion.
module viterbi_frame_ctrl #(
  parameter int unsigned TBL      = viterbi_pkg::TBL,
  parameter int unsigned TAIL_LEN = viterbi_pkg::TAIL_LEN,
  parameter int unsigned LEN_W    = viterbi_pkg::LEN_W
) (
  input logic                 clk,
  input logic                 rst_n,
  viterbi_frame_ctrl_if.master bus
);
  import viterbi_pkg::*;

  localparam logic [LEN_W-1:0] MIN_LEN    = LEN_W'(TAIL_LEN + 1);
  localparam logic [LEN_W-1:0] TAIL_W     = LEN_W'(TAIL_LEN);
  localparam logic [LEN_W-1:0] FLUSH_LAST = LEN_W'(TBL - 1);
  localparam logic [LEN_W-1:0] FLUSH_MAX  = LEN_W'(TBL);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] data_len;
  logic             err_q, abort_init_q;
  logic             dp_valid_q, out_valid_q, out_bit_q, out_last_q;
  logic [1:0]       dp_sym_q;
  logic             abortable, abort_now, start_ok, start_bad;
  logic             accept, dec_en, fwd, clear;
  logic [LEN_W-1:0] sym_cnt, flush_cnt, dec_cnt;
  logic             sym_tc, flush_tc, dec_tc;

  assign abortable = state inside {INIT, LOAD, FLUSH, DRAIN};
  assign abort_now = abortable & bus.abort_i;
  assign start_ok  = (state == IDLE) & bus.start_i & ~bus.abort_i & (bus.frame_len_i >= MIN_LEN);
  assign start_bad = (state == IDLE) & bus.start_i & ~bus.abort_i & (bus.frame_len_i < MIN_LEN);
  assign accept    = (state == LOAD) & bus.sym_valid_i;
  assign clear     = (state == INIT);
  assign data_len  = len_q - TAIL_W;
  // Stop counting at frame_len so stray strobes cannot push DRAIN past its exit.
  assign dec_en    = bus.dec_valid_i & (state inside {LOAD, FLUSH, DRAIN}) & ~dec_tc;
  assign fwd       = dec_en & ~bus.abort_i & (dec_cnt < data_len);

  vit_frame_cnt #(.W(LEN_W)) u_sym_cnt (
    .clk(clk), .rst_n(rst_n), .load(clear), .load_val('0),
    .inc(accept), .term(len_q - 1'b1), .count(sym_cnt), .tc(sym_tc)
  );

  vit_frame_cnt #(.W(LEN_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .load(clear), .load_val('0),
    .inc(state == FLUSH), .term(FLUSH_LAST), .count(flush_cnt), .tc(flush_tc)
  );

  vit_frame_cnt #(.W(LEN_W)) u_dec_cnt (
    .clk(clk), .rst_n(rst_n), .load(clear), .load_val('0),
    .inc(dec_en), .term(len_q), .count(dec_cnt), .tc(dec_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = INIT;
      INIT:    state_nxt = LOAD;
      LOAD:    if (accept && sym_tc) state_nxt = FLUSH;
      FLUSH:   if (flush_tc) state_nxt = DRAIN;
      DRAIN:   if (dec_tc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_now) state_nxt = IDLE;
  end

  always_comb begin
    bus.sym_ready_o = (state == LOAD);
    bus.dp_init_o   = (state == INIT) | abort_init_q;
    bus.busy_o      = (state != IDLE);
    bus.done_o      = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      err_q        <= 1'b0;
      abort_init_q <= 1'b0;
      dp_valid_q   <= 1'b0;
      dp_sym_q     <= '0;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      if (start_ok) len_q <= bus.frame_len_i;
      err_q        <= start_bad;
      abort_init_q <= abort_now;
      dp_valid_q   <= ~abort_now & (accept | (state == FLUSH));
      dp_sym_q     <= (accept & ~abort_now) ? bus.sym_i : 2'b00;
      out_valid_q  <= fwd;
      out_bit_q    <= fwd & bus.dec_bit_i;
      out_last_q   <= fwd & (dec_cnt == data_len - 1'b1);
    end
  end

  assign bus.err_o      = err_q;
  assign bus.dp_valid_o = dp_valid_q;
  assign bus.dp_sym_o   = dp_sym_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_bit_o  = out_bit_q;
  assign bus.out_last_o = out_last_q;

  a_cnt_bounds: assert property (@(posedge clk) disable iff (!rst_n)
    (state inside {LOAD, FLUSH, DRAIN}) |-> (sym_cnt <= len_q && flush_cnt <= FLUSH_MAX));

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl with a behavioural TBU stand-in.
module tb_viterbi_frame_ctrl;
  localparam int unsigned P_TBL  = 15;
  localparam int unsigned P_TAIL = 2;
  localparam int unsigned P_LW   = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  viterbi_frame_ctrl_if #(.LEN_W(P_LW)) bus ();

  viterbi_frame_ctrl #(.TBL(P_TBL), .TAIL_LEN(P_TAIL), .LEN_W(P_LW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  int tests = 0;
  int fails = 0;
  logic [1:0] symq[$];
  logic [1:0] bitq[$];
  int cur_len = 0;
  bit in_frame = 1'b0;
  int n_dp, n_out, n_last, n_done, n_err, n_init;
  int strobes = 0;
  int dm_idx;
  logic dm_bit;
  logic [1:0] exp_e;
  int l;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int out_vec();
    return int'({bus.sym_ready_o, bus.dp_init_o, bus.dp_valid_o, bus.dp_sym_o,
                 bus.out_valid_o, bus.out_bit_o, bus.out_last_o,
                 bus.busy_o, bus.done_o, bus.err_o});
  endfunction

  // TBU stand-in: one decoded bit per strobe once TBL strobes have filled the history.
  always @(negedge clk) begin
    bus.dec_valid_i = 1'b0;
    bus.dec_bit_i   = 1'b0;
    if (!rst_n) begin
      strobes = 0;
    end else if (!in_frame) begin
      strobes = 0;
      bus.dec_valid_i = 1'($urandom);
      bus.dec_bit_i   = 1'($urandom);
    end else if (bus.dp_valid_o) begin
      strobes++;
      if (strobes > int'(P_TBL)) begin
        dm_idx = strobes - int'(P_TBL);
        dm_bit = 1'($urandom);
        bus.dec_valid_i = 1'b1;
        bus.dec_bit_i   = dm_bit;
        if (dm_idx <= cur_len - int'(P_TAIL))
          bitq.push_back({dm_bit, 1'(dm_idx == cur_len - int'(P_TAIL))});
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dp_valid_o) begin
        n_dp++;
        if (symq.size() == 0) check("dp_unexpected", int'(bus.dp_valid_o), 0);
        else check("dp_sym", int'(bus.dp_sym_o), int'(symq.pop_front()));
      end
      if (bus.out_valid_o) begin
        n_out++;
        if (bus.out_last_o) n_last++;
        if (bitq.size() == 0) check("out_unexpected", int'(bus.out_valid_o), 0);
        else begin
          exp_e = bitq.pop_front();
          check("out_bit", int'(bus.out_bit_o), int'(exp_e[1]));
          check("out_last", int'(bus.out_last_o), int'(exp_e[0]));
        end
      end
      if (bus.done_o)    n_done++;
      if (bus.err_o)     n_err++;
      if (bus.dp_init_o) n_init++;
    end
  end

  task automatic clear_counts();
    n_dp = 0; n_out = 0; n_last = 0; n_done = 0; n_err = 0; n_init = 0;
  endtask

  task automatic start_frame(input int len);
    clear_counts();
    cur_len = len;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.frame_len_i = P_LW'(len);
    in_frame = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("busy_in_init", int'(bus.busy_o), 1);
    check("init_pulse", int'(bus.dp_init_o), 1);
  endtask

  task automatic feed(input int target, input int gap_mode, input int restart_at);
    int n = 0;
    int guard = 0;
    bit alt = 1'b0;
    bit v;
    while (n < target && guard < 4000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = alt;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      alt = ~alt;
      bus.sym_valid_i = v;
      bus.sym_i = 2'($urandom);
      bus.start_i = (n == restart_at);
      bus.frame_len_i = (n == restart_at) ? P_LW'(3) : P_LW'(cur_len);
      if (v && bus.sym_ready_o) begin
        symq.push_back(bus.sym_i);
        n++;
        if (n == cur_len) repeat (P_TBL) symq.push_back(2'b00);
      end
      @(negedge clk);
      guard++;
    end
    bus.sym_valid_i = 1'b0;
    bus.start_i = 1'b0;
    check("sym_accept_count", n, target);
  endtask

  task automatic finish_frame(input int len);
    int guard = 0;
    while (!bus.done_o && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("done_pulse", int'(bus.done_o), 1);
    @(negedge clk);
    in_frame = 1'b0;
    check("done_one_cycle", int'(bus.done_o), 0);
    check("busy_after_done", int'(bus.busy_o), 0);
    check("dp_strobes", n_dp, len + int'(P_TBL));
    check("out_count", n_out, len - int'(P_TAIL));
    check("out_last_count", n_last, 1);
    check("done_count", n_done, 1);
    check("init_count", n_init, 1);
    check("err_count", n_err, 0);
    check("sym_queue_left", symq.size(), 0);
    check("bit_queue_left", bitq.size(), 0);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.frame_len_i = '0;
    bus.abort_i = 1'b0;
    bus.sym_valid_i = 1'b0;
    bus.sym_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    start_frame(20); feed(20, 0, -1); finish_frame(20);
    start_frame(20); feed(20, 1, -1); finish_frame(20);

    // Too-short frame
    clear_counts();
    @(negedge clk);
    bus.start_i = 1'b1; bus.frame_len_i = P_LW'(P_TAIL);
    @(negedge clk);
    bus.start_i = 1'b0;
    check("short_err", int'(bus.err_o), 1);
    check("short_busy", int'(bus.busy_o), 0);
    @(negedge clk);
    check("short_err_one_cycle", int'(bus.err_o), 0);
    repeat (3) @(negedge clk);
    check("short_no_init", n_init, 0);
    check("short_err_count", n_err, 1);

    // Abort and start together in IDLE
    clear_counts();
    bus.start_i = 1'b1; bus.abort_i = 1'b1; bus.frame_len_i = P_LW'(20);
    @(negedge clk);
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    check("abort_start_busy", int'(bus.busy_o), 0);
    repeat (3) @(negedge clk);
    check("abort_start_no_init", n_init, 0);
    check("abort_start_no_err", n_err, 0);

    // Start re-asserted during LOAD
    start_frame(20); feed(20, 0, 5); finish_frame(20);

    // Abort after 7 symbols
    start_frame(20); feed(7, 0, -1);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    check("abort_idle", int'(bus.busy_o), 0);
    check("abort_init_pulse", int'(bus.dp_init_o), 1);
    @(negedge clk);
    in_frame = 1'b0;
    check("abort_init_one_cycle", int'(bus.dp_init_o), 0);
    repeat (30) @(negedge clk);
    check("abort_no_out", n_out, 0);
    check("abort_no_done", n_done, 0);
    check("abort_init_count", n_init, 2);
    check("abort_dp_strobes", n_dp, 7);
    check("abort_sym_queue", symq.size(), 0);

    // Reset during FLUSH
    start_frame(20); feed(20, 0, -1);
    for (int g = 0; g < 200 && n_dp < 26; g++) @(negedge clk);
    check("reached_flush", int'(n_dp >= 26), 1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_flush_outputs", out_vec(), 0);
    symq.delete();
    bitq.delete();
    in_frame = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", int'(bus.busy_o), 0);
    start_frame(20); feed(20, 0, -1); finish_frame(20);

    // Minimum legal length, then randomized frames
    start_frame(3); feed(3, 2, -1); finish_frame(3);
    for (int i = 0; i < 6; i++) begin
      l = $urandom_range(3, 48);
      start_frame(l); feed(l, 2, -1); finish_frame(l);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, got 1 expected 0");
    $fatal(1, "watchdog");
  end

endmodule
